// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Contents: data width, access-size encodings, MEM FSM state type and a
// helper that flags naturally misaligned half/word addresses.
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;

  // Access-size encodings carried on mem_size_in; 2'b11 is treated as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } mem_state_e;

  // True for a half access on an odd byte or a word access off a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (size == SZ_HALF) begin
      mis = addr_lo[0];
    end else if (size != SZ_BYTE) begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port (purely combinational).
// Ports:
//   size        in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD, 2'b11 = word)
//   is_unsigned in  1   zero-extend loads when set
//   addr_lo     in  2   low address bits, selects the lane (little-endian)
//   store_data  in  32  register value to store
//   rdata       in  32  raw word from memory
//   be          out 4   byte enables
//   wdata       out 32  lane-replicated store data
//   load_data   out 32  selected lane, sign/zero extended
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    // Half lanes use addr[1] only; addr[0] is ignored (truncated address).
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = is_unsigned ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage feeding the MEM/WB register.
// Performs loads/stores over a req/ack data-memory port, aligns and extends
// load data, and stalls upstream stages while an access is outstanding.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses (no request issued, misalign_err pulse, writeback suppressed).
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   valid_in .. write_reg_in       EX/MEM bundle
//   dmem_req/we/addr/be/wdata      data-memory request side
//   dmem_rdata, dmem_ack           data-memory response side
//   stall_out                      freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_enable                      MEM/WB enable
//   instr_out .. write_reg_out     writeback bundle
//   bus_error                      one-cycle pulse on ack timeout
//   misalign_err                   (MEM_ALIGN_CHECK_EN only) misalign pulse
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic [31:0]       instr_in,
  input  logic              reg_write_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        mem_size_in,
  input  logic              mem_unsigned_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        write_reg_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_out,
  output logic              wb_enable,
  output logic [31:0]       instr_out,
  output logic              reg_write_out,
  output logic              mem_to_reg_out,
  output logic [DATA_W-1:0] output_data,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [4:0]        write_reg_out,
  output logic              bus_error
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYCLES);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              kill_q, kill_d;     // suppress register write in DONE
  logic              bus_err_q, bus_err_d;
  logic              req, stall, wb_en;
  logic              mem_op, misalign;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata, lane_load;

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign misalign = is_misaligned(mem_size_in, alu_result_in[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign mem_op  = mem_read_in | mem_write_in;
  assign cnt_inc = cnt_q + CNT_W'(1);

  mem_lane_align u_lane_align (
    .size        (mem_size_in),
    .is_unsigned (mem_unsigned_in),
    .addr_lo     (alu_result_in[1:0]),
    .store_data  (store_data_in),
    .rdata       (dmem_rdata),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .load_data   (lane_load)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    kill_d    = kill_q;
    bus_err_d = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    req       = 1'b0;
    stall     = 1'b0;
    wb_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        kill_d = 1'b0;
        if (valid_in) begin
          if (!mem_op) begin
            wb_en = 1'b1;
          end else if (misalign) begin
            // Trap without touching memory; hold the slot one cycle then retire.
            stall   = 1'b1;
            state_d = StDone;
            kill_d  = 1'b1;
            rdata_d = '0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_d   = 1'b1;
`endif
          end else begin
            req   = 1'b1;
            stall = 1'b1;
            if (dmem_ack) begin
              state_d = StDone;
              rdata_d = mem_read_in ? lane_load : '0;
            end else begin
              state_d = StWait;
            end
          end
        end
      end
      StWait: begin
        // dmem_* stay stable: they derive from EX/MEM, which is frozen by stall.
        req   = 1'b1;
        stall = 1'b1;
        cnt_d = cnt_inc;
        if (dmem_ack) begin
          state_d = StDone;
          rdata_d = mem_read_in ? lane_load : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutCnt)) begin
          state_d   = StDone;
          kill_d    = 1'b1;
          bus_err_d = 1'b1;
          rdata_d   = '0;
        end
      end
      StDone: begin
        wb_en   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rdata_q   <= '0;
      kill_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      kill_q    <= kill_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign misalign_err = mis_q;
`endif

  // Gate with reset_n so an asserted reset silences the port and pipeline at once.
  assign dmem_req   = reset_n & req;
  assign stall_out  = reset_n & stall;
  assign wb_enable  = reset_n & wb_en;

  assign dmem_we    = dmem_req & mem_write_in;
  assign dmem_addr  = {alu_result_in[DATA_W-1:2], 2'b00};
  assign dmem_be    = dmem_req ? lane_be : 4'b0000;
  assign dmem_wdata = lane_wdata;

  assign instr_out      = instr_in;
  assign mem_to_reg_out = mem_to_reg_in;
  assign alu_result_out = alu_result_in;
  assign write_reg_out  = write_reg_in;
  assign reg_write_out  = wb_enable & reg_write_in & ~((state_q == StDone) & kill_q);
  assign output_data    = (state_q == StDone) ? rdata_q : '0;
  assign bus_error      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: table-driven memory ops, a
// writeback scoreboard, and hand-written reset/timeout/pass-through sequences.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [1:0]  mem_size_in = 2'b10;
  logic        mem_unsigned_in = 1'b0;
  logic [31:0] alu_result_in = '0, store_data_in = '0;
  logic [4:0]  write_reg_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        stall_out, wb_enable, reg_write_out, mem_to_reg_out, bus_error;
  logic [31:0] instr_out, output_data, alu_result_out;
  logic [4:0]  write_reg_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .valid_in(valid_in), .instr_in(instr_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in), .write_reg_in(write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall_out(stall_out), .wb_enable(wb_enable), .instr_out(instr_out),
    .reg_write_out(reg_write_out), .mem_to_reg_out(mem_to_reg_out),
    .output_data(output_data), .alu_result_out(alu_result_out),
    .write_reg_out(write_reg_out), .bus_error(bus_error)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int berr_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] data;
    logic [31:0] alu;
    logic [4:0]  wreg;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Writeback scoreboard: every MEM/WB enable must match the oldest expectation.
  always @(negedge clock) begin
    if (bus_error) berr_cnt++;
    if (reset_n && wb_enable) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_wb", {31'h0, wb_enable}, 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_instr", instr_out, mon_e.instr);
        chk("sb_reg_write", {31'h0, reg_write_out}, {31'h0, mon_e.reg_write});
        chk("sb_data", output_data, mon_e.data);
        chk("sb_alu", alu_result_out, mon_e.alu);
        chk("sb_wreg", {27'h0, write_reg_out}, {27'h0, mon_e.wreg});
      end
    end
  end

  task automatic run_mem(input vec_t v, input int idx);
    int stalls;
    bit done;
    stalls = 0;
    done = 1'b0;
    @(posedge clock); #1;
    valid_in = 1'b1; instr_in = 32'h8C00_0000 | idx; mem_read_in = v.rd; mem_write_in = v.wr;
    reg_write_in = v.rd; mem_to_reg_in = v.rd; mem_size_in = v.size; mem_unsigned_in = v.uns;
    alu_result_in = v.addr; store_data_in = v.sdata; write_reg_in = 5'(idx + 1);
    dmem_rdata = v.rdata; dmem_ack = (v.delay == 0);
    sb_q.push_back('{instr_in, v.rd, v.rd ? v.data : 32'h0, v.addr, write_reg_in});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (wb_enable) begin
        done = 1'b1;
      end else begin
        stalls++;
        chk("op_stall", {31'h0, stall_out}, 32'h1);
        chk("op_req", {31'h0, dmem_req}, 32'h1);
        chk("op_addr", dmem_addr, {v.addr[31:2], 2'b00});
        chk("op_be", {28'h0, dmem_be}, {28'h0, v.be});
        chk("op_we", {31'h0, dmem_we}, {31'h0, v.wr});
        if (v.wr) chk("op_wdata", dmem_wdata, v.wdata);
        @(posedge clock); #1;
        dmem_ack = ((k + 1) == v.delay);
      end
    end
    chk("op_done_reached", {31'h0, done}, 32'h1);
    chk("op_stall_cycles", stalls, v.delay + 1);
    chk("op_done_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; dmem_ack = 1'b0;
    @(negedge clock);
    chk("op_wb_one_cycle", {31'h0, wb_enable}, 32'h0);
    chk("op_idle_stall", {31'h0, stall_out}, 32'h0);
  endtask

  initial begin
    int stalls;
    bit done;
    int berr_before;
    //            rd    wr    size   uns   addr      sdata         rdata          dly be       wdata          data
    vecs[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80FF_0000, 3, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'hBEEF_1234, 1, 4'b1100, 32'h0,        32'h0000_BEEF};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'hAB,       32'h0,         2, 4'b0010, 32'hABAB_ABAB, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0,        32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0,        32'h1234_8001, 2, 4'b0011, 32'h0,        32'hFFFF_8001};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h0,        32'h0000_9A00, 1, 4'b0010, 32'h0,        32'h0000_009A};
    vecs[6] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h402, 32'h1234_CAFE, 32'h0,        1, 4'b1100, 32'hCAFE_CAFE, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h500, 32'h1122_3344, 32'h0,        0, 4'b1111, 32'h1122_3344, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h600, 32'h0,        32'hA5A5_0F0F, 1, 4'b1111, 32'h0,        32'hA5A5_0F0F};
    vecs[9] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0,        32'h007F_0000, 2, 4'b0100, 32'h0,        32'h0000_007F};

    // Reset: a live load on the inputs must not leak out while reset is held.
    valid_in = 1'b1; mem_read_in = 1'b1;
    #12;
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_wb", {31'h0, wb_enable}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_berr", {31'h0, bus_error}, 32'h0);
    chk("rst_data", output_data, 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0; mem_read_in = 1'b0;
    reset_n = 1'b1;

    // Bubble: no writeback even with reg_write_in set.
    reg_write_in = 1'b1;
    @(negedge clock);
    chk("bubble_wb", {31'h0, wb_enable}, 32'h0);
    chk("bubble_rw", {31'h0, reg_write_out}, 32'h0);

    // R-type pass-through, zero latency.
    @(posedge clock); #1;
    valid_in = 1'b1; reg_write_in = 1'b1; alu_result_in = 32'h1234; instr_in = 32'h0000_0020;
    write_reg_in = 5'd3;
    sb_q.push_back('{32'h0000_0020, 1'b1, 32'h0, 32'h1234, 5'd3});
    @(negedge clock);
    chk("rtype_wb", {31'h0, wb_enable}, 32'h1);
    chk("rtype_stall", {31'h0, stall_out}, 32'h0);
    chk("rtype_alu", alu_result_out, 32'h1234);
    chk("rtype_req", {31'h0, dmem_req}, 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0;

    for (int i = 0; i < 10; i++) run_mem(vecs[i], i);

    // Timeout: ack never comes.
    berr_before = berr_cnt;
    stalls = 0;
    done = 1'b0;
    @(posedge clock); #1;
    valid_in = 1'b1; mem_read_in = 1'b1; reg_write_in = 1'b1; mem_size_in = 2'b10;
    alu_result_in = 32'h700; instr_in = 32'h8C00_0700; write_reg_in = 5'd7; dmem_ack = 1'b0;
    sb_q.push_back('{32'h8C00_0700, 1'b0, 32'h0, 32'h700, 5'd7});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      if (wb_enable) done = 1'b1;
      else begin
        stalls++;
        @(posedge clock); #1;
      end
    end
    chk("to_done_reached", {31'h0, done}, 32'h1);
    chk("to_stall_cycles", stalls, TO + 1);
    chk("to_berr_in_done", {31'h0, bus_error}, 32'h1);
    chk("to_rw_killed", {31'h0, reg_write_out}, 32'h0);
    chk("to_data_zero", output_data, 32'h0);
    chk("to_req_dropped", {31'h0, dmem_req}, 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0; mem_read_in = 1'b0; dmem_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("late_ack_wb", {31'h0, wb_enable}, 32'h0);
      chk("late_ack_req", {31'h0, dmem_req}, 32'h0);
      chk("late_ack_berr", {31'h0, bus_error}, 32'h0);
      chk("late_ack_stall", {31'h0, stall_out}, 32'h0);
      @(posedge clock); #1;
    end
    dmem_ack = 1'b0;
    chk("to_berr_pulses", berr_cnt - berr_before, 1);

    // Reset asserted while waiting for ack.
    valid_in = 1'b1; mem_read_in = 1'b1; alu_result_in = 32'h800;
    @(negedge clock);
    chk("rw_req_idle", {31'h0, dmem_req}, 32'h1);
    @(posedge clock); #1;
    @(negedge clock);
    chk("rw_wait_stall", {31'h0, stall_out}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rw_req_async", {31'h0, dmem_req}, 32'h0);
    chk("rw_wb_async", {31'h0, wb_enable}, 32'h0);
    chk("rw_stall_async", {31'h0, stall_out}, 32'h0);
    valid_in = 1'b0; mem_read_in = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    // In IDLE an R-type must retire in the same cycle.
    valid_in = 1'b1; reg_write_in = 1'b1; alu_result_in = 32'h55; instr_in = 32'h0000_0055;
    write_reg_in = 5'd9;
    sb_q.push_back('{32'h0000_0055, 1'b1, 32'h0, 32'h55, 5'd9});
    @(negedge clock);
    chk("post_rst_wb", {31'h0, wb_enable}, 32'h1);
    chk("post_rst_stall", {31'h0, stall_out}, 32'h0);
    @(posedge clock); #1;
    valid_in = 1'b0;
    @(negedge clock);

    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage that sits directly upstream of the MEM/WB register.
- Takes EX/MEM outputs and performs loads and stores on a data-memory port with a req/ack handshake, aligning and sign/zero-extending load data.
- Delivers a writeback bundle plus a write-enable strobe to MEM/WB, and stalls upstream stages while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles to wait for dmem_ack before aborting; 0 means wait forever.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- valid_in  in  1  EX/MEM slot holds a live instruction
- instr_in  in  32  instruction word
- reg_write_in, mem_to_reg_in, mem_read_in, mem_write_in  in  1 each  control bits
- mem_size_in  in  2  access size: 00 byte, 01 half, 10 word
- mem_unsigned_in  in  1  zero-extend loads when set
- alu_result_in  in  32  effective address or ALU result
- store_data_in  in  32  rt value for stores
- write_reg_in  in  5  destination register
- dmem_req  out  1  memory request
- dmem_we  out  1  store when 1, load when 0
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  load data
- dmem_ack  in  1  one-cycle completion
- stall_out  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- wb_enable  out  1  drives the MEM/WB enable input
- instr_out  out  32
- reg_write_out, mem_to_reg_out  out  1 each
- output_data  out  32  aligned and extended load data
- alu_result_out  out  32
- write_reg_out  out  5
- bus_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE, counter=0, load-data register=0, dmem_req=0, bus_error=0.
- Combinational outputs are gated so that at reset wb_enable=0 and stall_out=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, valid_in=0:
  - wb_enable=0 and reg_write_out=0, so no bubble write occurs.
- IDLE, valid_in=1 with no memory op:
  - Bundle passes through combinationally; wb_enable=1, stall_out=0; zero added latency.
- IDLE, valid_in=1 with mem_read_in or mem_write_in:
  - dmem_req=1 in the same cycle; stall_out=1; wb_enable=0; next state WAIT.
- WAIT:
  - Hold dmem_req and all dmem_* outputs stable; stall_out=1; counter increments each cycle.
  - dmem_ack=1: register the aligned load data, move to DONE.
  - Ack arriving in the same cycle the request is first raised in IDLE is accepted; go straight to DONE.
- DONE:
  - Exactly one cycle: wb_enable=1, stall_out=0, output_data driven from the register; next state IDLE.
  - Minimum memory-op latency is 2 cycles from entering IDLE with the op.
- Timeout (TIMEOUT_CYCLES>0, counter reaches TIMEOUT_CYCLES in WAIT with no ack):
  - Drop dmem_req, pulse bus_error, go to DONE with output_data=0 and reg_write_out forced 0.
  - A late ack arriving afterwards is ignored.
- Stores:
  - Complete through DONE the same way; reg_write_out is passed through (0 from decode).
- Byte lanes (little-endian, addr[1:0] selects the lane):
  - Byte: be=1<<addr[1:0], wdata={4{sd[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{sd[15:0]}}.
  - Word: be=1111.
- Load extension:
  - Select the lane from rdata and extend per mem_unsigned_in.
  - mem_size_in=11 is treated as word.
- Reset mid-access: return to IDLE immediately, drop dmem_req; the upstream pipeline is also reset.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- When defined:
  - Half access with addr[0]=1, or word access with addr[1:0]!=0, issues no dmem_req.
  - The stage enters DONE next cycle with reg_write_out=0 and pulses an extra output misalign_err for 1 cycle.
- When undefined:
  - The misalign_err port is absent.
  - Misaligned accesses use the lane rules above with the address truncated, i.e. no trap.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - FSM state encodings
  - a DATA_W=32 constant
- One natural sub-module, mem_lane_align: purely combinational; handles be/wdata generation and load extraction/extension. It is instantiated once.

Test Plan:
- R-type, valid_in=1, reg_write_in=1, alu_result_in=0x1234 -> same cycle: wb_enable=1, stall_out=0, alu_result_out=0x1234, dmem_req=0.
- lb at addr 0x103, rdata=0x80FF_0000, ack after 3 cycles -> stall_out high for 4 cycles; DONE shows output_data=0xFFFF_FF80 and wb_enable=1 for exactly one cycle.
- lhu at 0x102, rdata=0xBEEF_1234 -> output_data=0x0000_BEEF; dmem_addr=0x100.
- sb at 0x201, store_data=0xAB -> dmem_be=0010, dmem_wdata=0xABAB_ABAB, dmem_we=1; request held until ack.
- TIMEOUT_CYCLES=4 with ack never asserted -> bus_error pulses once, reg_write_out=0 in DONE, stall then releases; a late ack causes no change.
- reset_n pulled low during WAIT -> dmem_req=0, wb_enable=0 and stall_out=0 immediately (asynchronous); state is IDLE after release.
